// File: rtl/bc_io_pkg.sv
// Shared constants for the basic-computer I/O and interrupt controller:
// interrupt-cycle state encoding, I/O instruction bit positions and opcode.
package bc_io_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRt0  = 2'd1;
    localparam state_t StRt1  = 2'd2;
    localparam state_t StRt2  = 2'd3;

    // Bit positions within IR; io_bits carries IR[11:6].
    localparam int unsigned IrInp = 11;
    localparam int unsigned IrOut = 10;
    localparam int unsigned IrSki = 9;
    localparam int unsigned IrSko = 8;
    localparam int unsigned IrIon = 7;
    localparam int unsigned IrIof = 6;
    localparam int unsigned IoLsb = 6;

    localparam logic [3:0] IoOpcode = 4'hF;

    function automatic int unsigned io_idx(input int unsigned ir_bit);
        return ir_bit - IoLsb;
    endfunction

endpackage

// File: rtl/bc_io_flags.sv
// IEN, FGO and OUTR registers plus decode of the six I/O instructions.
// io_en is already qualified by the top (idle, no pending interrupt entry).
module bc_io_flags
    import bc_io_pkg::*;
#(
    parameter int unsigned CHAR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_en,
    input  logic [5:0]        io_bits,
    input  logic              FGI,
    input  logic [CHAR_W-1:0] ac_lo,
    input  logic              out_ack,
    input  logic              ien_clr,
    output logic              ien,
    output logic              fgo,
    output logic [CHAR_W-1:0] outr,
    output logic              skip,
    output logic              ac_ld_inpr,
    output logic              fgi_clr
);

    logic              ien_q, ien_d;
    logic              fgo_q, fgo_d;
    logic [CHAR_W-1:0] outr_q, outr_d;
    logic              do_inp, do_out, do_ski, do_sko, do_ion, do_iof;

    assign do_inp = io_en & io_bits[io_idx(IrInp)];
    assign do_out = io_en & io_bits[io_idx(IrOut)];
    assign do_ski = io_en & io_bits[io_idx(IrSki)];
    assign do_sko = io_en & io_bits[io_idx(IrSko)];
    assign do_ion = io_en & io_bits[io_idx(IrIon)];
    assign do_iof = io_en & io_bits[io_idx(IrIof)];

    assign skip       = (do_ski & FGI) | (do_sko & fgo_q);
    assign ac_ld_inpr = do_inp;
    assign fgi_clr    = do_inp;

    always_comb begin
        ien_d  = ien_q;
        fgo_d  = fgo_q;
        outr_d = outr_q;
        // IOF beats ION; the end of an interrupt cycle beats both.
        if (ien_clr || do_iof) begin
            ien_d = 1'b0;
        end else if (do_ion) begin
            ien_d = 1'b1;
        end
        if (do_out) begin
            fgo_d  = 1'b0;
            outr_d = ac_lo;
        end else if (out_ack) begin
            fgo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ien_q  <= 1'b0;
            fgo_q  <= 1'b1;
            outr_q <= '0;
        end else begin
            ien_q  <= ien_d;
            fgo_q  <= fgo_d;
            outr_q <= outr_d;
        end
    end

    assign ien  = ien_q;
    assign fgo  = fgo_q;
    assign outr = outr_q;

endmodule

// File: rtl/bc_io_int_ctrl.sv
// Interrupt/I-O controller top: interrupt request flip-flop R and the
// RT0-RT2 interrupt-cycle sequencer with Moore data-path strobes.
module bc_io_int_ctrl
    import bc_io_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CHAR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FGI,
    input  logic [CHAR_W-1:0] inpr,
    input  logic              out_ack,
    input  logic [CHAR_W-1:0] ac_lo,
    input  logic              in_fetch,
    input  logic              at_t0,
    input  logic              io_valid,
    input  logic [5:0]        io_bits,
    output logic              int_req,
    output logic              ien,
    output logic              fgo,
    output logic [CHAR_W-1:0] outr,
    output logic              fgi_clr,
    output logic              ac_ld_inpr,
    output logic              skip,
    output logic              int_active,
    output logic              ar_clr,
    output logic              tr_ld_pc,
    output logic              mem_wr_tr,
    output logic              pc_clr,
    output logic              pc_inc,
    output logic              sc_clr,
    output logic              int_done
);

    if (ADDR_W > WIDTH || CHAR_W > WIDTH) begin : g_cfg_check
        $error("bc_io_int_ctrl: ADDR_W and CHAR_W must not exceed WIDTH");
    end

    state_t state_q, state_d;
    logic   r_q, r_d;
    logic   idle, enter_int, io_en;

    // inpr is routed to AC by the data path; this block only issues the strobe.
    logic unused_inpr;
    assign unused_inpr = ^inpr;

    assign idle      = (state_q == StIdle);
    assign enter_int = idle & at_t0 & r_q;
    assign io_en     = io_valid & idle & ~enter_int;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enter_int) state_d = StRt0;
            StRt0:   state_d = StRt1;
            StRt1:   state_d = StRt2;
            StRt2:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        r_d = r_q;
        if (state_q == StRt2) begin
            r_d = 1'b0;
        end else if (idle && !in_fetch && ien && (FGI || fgo)) begin
            r_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    bc_io_flags #(
        .CHAR_W (CHAR_W)
    ) u_flags (
        .clk        (clk),
        .rst        (rst),
        .io_en      (io_en),
        .io_bits    (io_bits),
        .FGI        (FGI),
        .ac_lo      (ac_lo),
        .out_ack    (out_ack),
        .ien_clr    (state_q == StRt2),
        .ien        (ien),
        .fgo        (fgo),
        .outr       (outr),
        .skip       (skip),
        .ac_ld_inpr (ac_ld_inpr),
        .fgi_clr    (fgi_clr)
    );

    assign int_req    = r_q;
    assign int_active = ~idle;
    assign ar_clr     = (state_q == StRt0);
    assign tr_ld_pc   = (state_q == StRt0);
    assign mem_wr_tr  = (state_q == StRt1);
    assign pc_clr     = (state_q == StRt1);
    assign pc_inc     = (state_q == StRt2);
    assign sc_clr     = (state_q == StRt2);
    assign int_done   = (state_q == StRt2);

endmodule

// File: tb/tb_bc_io_int_ctrl.sv
// Self-checking bench for bc_io_int_ctrl: directed scenarios followed by
// random stimulus, all compared against a cycle-level behavioural model.
module tb_bc_io_int_ctrl;

    logic       clk = 1'b0;
    logic       rst, fgi, out_ack, in_fetch, at_t0, io_valid;
    logic [7:0] inpr, ac_lo;
    logic [5:0] io_bits;

    logic       int_req, ien, fgo, fgi_clr, ac_ld_inpr, skip, int_active;
    logic       ar_clr, tr_ld_pc, mem_wr_tr, pc_clr, pc_inc, sc_clr, int_done;
    logic [7:0] outr;

    int total = 0;
    int bad   = 0;

    // Model: flags plus the number of interrupt-cycle cycles still to run.
    logic       m_r, m_ien, m_fgo;
    logic [7:0] m_outr;
    int         m_left;
    bit         model_ok = 0;

    always #5 clk = ~clk;

    bc_io_int_ctrl #(
        .WIDTH  (16),
        .ADDR_W (12),
        .CHAR_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .FGI        (fgi),
        .inpr       (inpr),
        .out_ack    (out_ack),
        .ac_lo      (ac_lo),
        .in_fetch   (in_fetch),
        .at_t0      (at_t0),
        .io_valid   (io_valid),
        .io_bits    (io_bits),
        .int_req    (int_req),
        .ien        (ien),
        .fgo        (fgo),
        .outr       (outr),
        .fgi_clr    (fgi_clr),
        .ac_ld_inpr (ac_ld_inpr),
        .skip       (skip),
        .int_active (int_active),
        .ar_clr     (ar_clr),
        .tr_ld_pc   (tr_ld_pc),
        .mem_wr_tr  (mem_wr_tr),
        .pc_clr     (pc_clr),
        .pc_inc     (pc_inc),
        .sc_clr     (sc_clr),
        .int_done   (int_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit io_take();
        return io_valid && (m_left == 0) && !(at_t0 && m_r);
    endfunction

    task automatic check_all();
        bit take;
        take = io_take();
        check("int_req", int_req, m_r);
        check("ien", ien, m_ien);
        check("fgo", fgo, m_fgo);
        check("outr", outr, m_outr);
        check("int_active", int_active, m_left != 0);
        check("ar_clr", ar_clr, m_left == 3);
        check("tr_ld_pc", tr_ld_pc, m_left == 3);
        check("mem_wr_tr", mem_wr_tr, m_left == 2);
        check("pc_clr", pc_clr, m_left == 2);
        check("pc_inc", pc_inc, m_left == 1);
        check("sc_clr", sc_clr, m_left == 1);
        check("int_done", int_done, m_left == 1);
        check("skip", skip, take && ((io_bits[3] && fgi) || (io_bits[2] && m_fgo)));
        check("ac_ld_inpr", ac_ld_inpr, take && io_bits[5]);
        check("fgi_clr", fgi_clr, take && io_bits[5]);
    endtask

    task automatic model_update();
        logic       n_r, n_ien, n_fgo;
        logic [7:0] n_outr;
        int         n_left;
        bit         take, idle;
        if (rst) begin
            m_r = 0; m_ien = 0; m_fgo = 1; m_outr = 8'h00; m_left = 0;
            model_ok = 1;
        end else begin
            idle = (m_left == 0);
            take = io_take();
            n_r = m_r; n_ien = m_ien; n_fgo = m_fgo; n_outr = m_outr; n_left = m_left;
            if (!idle) begin
                n_left = m_left - 1;
                if (m_left == 1) begin
                    n_r = 0;
                    n_ien = 0;
                end
            end else if (at_t0 && m_r) begin
                n_left = 3;
            end
            if (idle && !in_fetch && m_ien && (fgi || m_fgo)) n_r = 1;
            if (take && io_bits[0]) n_ien = 0;
            else if (take && io_bits[1]) n_ien = 1;
            if (take && io_bits[4]) begin
                n_fgo = 0;
                n_outr = ac_lo;
            end else if (out_ack) begin
                n_fgo = 1;
            end
            m_r = n_r; m_ien = n_ien; m_fgo = n_fgo; m_outr = n_outr; m_left = n_left;
        end
    endtask

    // Move to the low phase and load quiet default inputs.
    task automatic nxt();
        @(negedge clk);
        rst = 0; fgi = 0; inpr = 8'h3C; out_ack = 0; ac_lo = 8'h00;
        in_fetch = 1; at_t0 = 0; io_valid = 0; io_bits = 6'b0;
    endtask

    // Check everything against the model, take the clock edge, advance model.
    task automatic tick();
        #2;
        if (model_ok) check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        // Reset
        nxt(); rst = 1; tick();
        nxt(); rst = 1; tick();
        check("rst_r", int_req, 0);
        check("rst_ien", ien, 0);
        check("rst_fgo", fgo, 1);
        check("rst_outr", outr, 8'h00);
        check("rst_strobes", {ar_clr, tr_ld_pc, mem_wr_tr, pc_clr, pc_inc, sc_clr, int_done,
                              int_active}, 8'h00);

        // OUT, then acknowledge, then OUT racing an acknowledge
        nxt(); io_valid = 1; io_bits = 6'b010000; ac_lo = 8'hA5; tick();
        check("out_outr", outr, 8'hA5);
        check("out_fgo", fgo, 0);
        nxt(); out_ack = 1; tick();
        check("ack_fgo", fgo, 1);
        nxt(); io_valid = 1; io_bits = 6'b010000; ac_lo = 8'h5A; out_ack = 1; tick();
        check("out_ack_fgo", fgo, 0);
        check("out_ack_outr", outr, 8'h5A);

        // SKI, SKO, INP
        nxt(); fgi = 1; io_valid = 1; io_bits = 6'b001000; #1;
        check("ski_skip", skip, 1);
        tick();
        nxt(); io_valid = 1; io_bits = 6'b000100; #1;
        check("sko_skip", skip, 0);
        tick();
        nxt(); fgi = 1; io_valid = 1; io_bits = 6'b100000; #1;
        check("inp_ld", ac_ld_inpr, 1);
        check("inp_clr", fgi_clr, 1);
        tick();

        // Full interrupt cycle
        nxt(); io_valid = 1; io_bits = 6'b000010; tick();
        check("ion_ien", ien, 1);
        nxt(); fgi = 1; in_fetch = 0; tick();
        check("r_set", int_req, 1);
        nxt(); at_t0 = 1; tick();
        check("rt0", {ar_clr, tr_ld_pc, int_active}, 3'b111);
        nxt(); tick();
        check("rt1", {mem_wr_tr, pc_clr, ar_clr}, 3'b110);
        nxt(); tick();
        check("rt2", {pc_inc, sc_clr, int_done, mem_wr_tr}, 4'b1110);
        nxt(); tick();
        check("post_int", {int_req, ien, int_active}, 3'b000);

        // ION+IOF together leaves interrupts off; R must not set
        nxt(); io_valid = 1; io_bits = 6'b000011; tick();
        check("ion_iof_ien", ien, 0);
        for (int i = 0; i < 20; i++) begin
            nxt(); fgi = 1; in_fetch = 0; tick();
            check("r_stays_0", int_req, 0);
        end

        // Reset in RT1
        nxt(); io_valid = 1; io_bits = 6'b000010; tick();
        nxt(); fgi = 1; in_fetch = 0; tick();
        nxt(); at_t0 = 1; tick();
        nxt(); tick();
        check("rt1_before_rst", mem_wr_tr, 1);
        nxt(); rst = 1; tick();
        check("rst_rt1", {mem_wr_tr, pc_clr, int_active, ien, int_req}, 5'b00000);
        check("rst_rt1_fgo", fgo, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst      = ($urandom_range(199) == 0);
            fgi      = $urandom_range(1);
            inpr     = 8'($urandom);
            out_ack  = ($urandom_range(7) == 0);
            ac_lo    = 8'($urandom);
            in_fetch = $urandom_range(1);
            at_t0    = ($urandom_range(3) == 0);
            io_valid = ($urandom_range(2) == 0);
            io_bits  = 6'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
